// File: rtl/jtframe_fraccen_gen.sv
// Fractional clock-enable generator: cen[0] fires at n/m of the clock rate, with binary
// sub-divided enables (cen[k]) and half-phase enables (cenb). Optional window statistics on
// cen_cnt are enabled by defining JTFRAME_FRACCEN_STATS_EN.
module jtframe_fraccen_gen #(
  parameter int WC   = 10,
  parameter int W    = 3,
  parameter int CNTW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lock,
  input  logic [WC-1:0] n,
  input  logic [WC-1:0] m,
  output logic [W-1:0]  cen,
  output logic [W-2:0]  cenb,
  output logic [CNTW:0] cen_cnt
);

  logic          lock_m, lock_s;
  logic [WC:0]   acc, acc_nx;
  logic [WC+1:0] sum;
  logic [W-2:0]  cnt;
  logic          pulse;
  logic [W-1:0]  cen_nx;
  logic [W-2:0]  cenb_nx;
  logic [W-2:0]  mask;

  // acc stays below 2^WC (it is always < previous m or < n), so the WC+1 bit result never truncates.
  always_comb begin
    sum    = {1'b0, acc} + {2'b00, n};
    pulse  = 1'b0;
    acc_nx = acc;
    if (!lock_s) begin
      acc_nx = '0;
    end else if (n != '0 && m != '0) begin
      if (n >= m) begin
        pulse  = 1'b1;
        acc_nx = '0;
      end else if (sum >= {2'b00, m}) begin
        pulse  = 1'b1;
        acc_nx = (WC+1)'(sum - {2'b00, m});
      end else begin
        acc_nx = sum[WC:0];
      end
    end
  end

  always_comb begin
    cen_nx    = '0;
    cenb_nx   = '0;
    mask      = '0;
    cen_nx[0] = pulse;
    for (int k = 1; k < W; k++) begin
      mask        = (W-1)'((1 << k) - 1);
      cen_nx[k]   = pulse && ((cnt & mask) == '0);
      cenb_nx[k-1] = pulse && ((cnt & mask) == (W-1)'(1 << (k-1)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      cen    <= '0;
      cenb   <= '0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
      acc    <= acc_nx;
      cnt    <= lock_s ? cnt + (W-1)'(pulse) : '0;
      cen    <= cen_nx;
      cenb   <= cenb_nx;
    end
  end

`ifdef JTFRAME_FRACCEN_STATS_EN
  localparam logic [CNTW:0] SAT = (CNTW+1)'(1) << CNTW;

  logic [CNTW-1:0] win;
  logic [CNTW:0]   pcnt, pcnt_inc;

  assign pcnt_inc = (cen[0] && pcnt != SAT) ? pcnt + 1'b1 : pcnt;

  // The wrap-cycle pulse is folded into the reported count; cen_cnt survives lock loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win     <= '0;
      pcnt    <= '0;
      cen_cnt <= '0;
    end else if (!lock_s) begin
      win  <= '0;
      pcnt <= '0;
    end else begin
      win <= win + 1'b1;
      if (win == '1) begin
        cen_cnt <= pcnt_inc;
        pcnt    <= '0;
      end else begin
        pcnt <= pcnt_inc;
      end
    end
  end
`else
  assign cen_cnt = '0;
`endif

endmodule

// File: tb/tb_jtframe_fraccen_gen.sv
// Bench for jtframe_fraccen_gen: a rate-level reference model pushes the expected enables
// each clock; an independent monitor pops and compares on the falling edge.
module tb_jtframe_fraccen_gen;
  localparam int WC   = 10;
  localparam int W    = 3;
  localparam int CNTW = 8;
  localparam int OW   = 2*W - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lock = 1'b0;
  logic [WC-1:0] n = '0;
  logic [WC-1:0] m = '0;
  logic [W-1:0]  cen;
  logic [W-2:0]  cenb;
  logic [CNTW:0] cen_cnt;

  jtframe_fraccen_gen #(.WC(WC), .W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .lock(lock), .n(n), .m(m),
    .cen(cen), .cenb(cenb), .cen_cnt(cen_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  // reference model state: fractional remainder, total pulses since lock, lock pipeline
  int m_acc = 0;
  int m_pc  = 0;
  bit m_l1  = 0;
  bit m_l2  = 0;

  int obs_pulses = 0;
  int adj_hits   = 0;
  bit prev_cen0  = 0;

  task automatic step();
    logic [W-1:0] c;
    logic [W-2:0] cb;
    bit pulse;
    c = '0; cb = '0; pulse = 0;
    if (rst) begin
      m_acc = 0; m_pc = 0; m_l1 = 0; m_l2 = 0;
    end else begin
      if (!m_l2) begin
        m_acc = 0; m_pc = 0;
      end else if (n != 0 && m != 0) begin
        if (int'(n) >= int'(m)) begin
          pulse = 1; m_acc = 0;
        end else if (m_acc + int'(n) >= int'(m)) begin
          pulse = 1; m_acc = m_acc + int'(n) - int'(m);
        end else begin
          m_acc = m_acc + int'(n);
        end
      end
      if (pulse) begin
        for (int k = 0; k < W; k++) c[k] = ((m_pc % (1 << k)) == 0);
        for (int k = 1; k < W; k++) cb[k-1] = ((m_pc % (1 << k)) == (1 << (k-1)));
        m_pc++;
      end
      m_l2 = m_l1;
      m_l1 = lock;
    end
    exp_q.push_back({cb, c});
  endtask

  task automatic cycle();
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) cycle();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({cenb, cen} !== e) begin
        errors++;
        $display("FAIL outs t=%0t got cenb,cen=%b exp=%b (n=%0d m=%0d lock=%0b)",
                 $time, {cenb, cen}, e, n, m, lock);
      end
      if (cen[0] === 1'b1) begin
        obs_pulses++;
        if (prev_cen0) adj_hits++;
      end
      prev_cen0 = (cen[0] === 1'b1);
`ifndef JTFRAME_FRACCEN_STATS_EN
      checks++;
      if (cen_cnt !== '0) begin
        errors++;
        $display("FAIL cen_cnt_tied t=%0t got=%0d exp=0", $time, cen_cnt);
      end
`endif
    end
  end

  initial begin
    // reset state, then n=1 m=8 start-up timing and sub-division
    rst = 1; lock = 1; n = 1; m = 8;
    run(3);
    rst = 0;
    run(80);

    // n=3 m=8 over exactly 800 decisions from a fresh reset
    rst = 1; n = 3; m = 8;
    cycle();
    rst = 0;
    obs_pulses = 0; adj_hits = 0;
    run(802);
    @(negedge clk); #1;
    checks++;
    if (obs_pulses != 800 * 3 / 8) begin
      errors++;
      $display("FAIL rate_3_8 got=%0d exp=%0d", obs_pulses, 800 * 3 / 8);
    end
    checks++;
    if (adj_hits != 0) begin
      errors++;
      $display("FAIL adjacent_3_8 got=%0d exp=0", adj_hits);
    end

    // n>=m pulses every cycle, then m=0 freezes
    n = 5; m = 5; run(20);
    n = 7; run(20);
    m = 0; run(20);
    n = 3; m = 8; run(30);

    // lock drop mid-run and recovery
    lock = 0; run(10);
    lock = 1; run(60);

    // runtime reduction of m below the remainder
    n = 7; m = 9; run(7);
    m = 2; run(10);

    // asynchronous reset mid-pulse
    n = 5; m = 5; run(10);
    @(negedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if (cen !== '0 || cenb !== '0) begin
      errors++;
      $display("FAIL async_rst got cen=%b cenb=%b exp=0", cen, cenb);
    end
    cycle();
    rst = 0;
    run(20);

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      lock = ($urandom_range(0, 5) != 0);
      n = WC'($urandom_range(0, 20));
      m = WC'($urandom_range(0, 20));
      run($urandom_range(5, 60));
    end
    lock = 1;

`ifdef JTFRAME_FRACCEN_STATS_EN
    n = 1; m = 4; run(900);
    @(negedge clk); #1;
    checks++;
    if (cen_cnt !== (CNTW+1)'(64)) begin
      errors++;
      $display("FAIL stats_1_4 got=%0d exp=64", cen_cnt);
    end
    n = 1; m = 1; run(900);
    @(negedge clk); #1;
    checks++;
    if (cen_cnt !== (CNTW+1)'(256)) begin
      errors++;
      $display("FAIL stats_1_1 got=%0d exp=256", cen_cnt);
    end
`endif

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_fraccen_gen.md
Name: jtframe_fraccen_gen

Overview:
- Fractional clock-enable generator fed by the system clock (clk48 or clk96) and pll_locked from the clock block.
- Produces a base enable cen[0] at a rate of n/m times the clock rate.
- Also produces binary sub-divided enables cen[k] and half-phase enables cenb[k] for the game cores.
- Stays silent until the PLL lock has been synchronised into the clock domain.

Parameters:
- WC, 10, width of the n and m ratio inputs
- W, 3, number of cen outputs (W>=2); cen[k] runs at rate(cen[0])/2^k
- CNTW, 8, stats window exponent (optional feature only)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- lock  input  1  PLL locked, asynchronous to clk
- n  input  WC  numerator
- m  input  WC  denominator
- cen  output  W  clock enables, one-cycle pulses
- cenb  output  W-1  half-phase enables for cen[1..W-1]
- cen_cnt  output  CNTW+1  cen[0] pulses in the last window (optional feature only)

Behaviour:
- Reset: rst is asynchronous and active-high. While it is asserted:
  - acc=0, cnt=0, lock sync flops=0.
  - cen=0, cenb=0, cen_cnt=0.
- Lock sync:
  - lock passes through a 2-flop synchroniser to give lock_s.
  - While lock_s=0: acc and cnt are held at 0 and all outputs are 0.
  - A lock drop mid-operation clears acc and cnt on the next cycle that lock_s=0 is seen. There is no partial pulse.
- Accumulator:
  - acc is WC+1 bits wide.
  - Each cycle with lock_s=1, compute sum = acc + n, zero-extended to WC+2 bits.
- Pulse decision:
  - m=0 or n=0: no pulse, and acc holds.
  - n>=m with m!=0: pulse every cycle, and acc<=0.
  - Otherwise, if sum>=m: pulse, and acc<=sum-m. Else acc<=sum.
  - If m is reduced at runtime so that acc>=m, pulses repeat every cycle until acc<m. No clamping beyond this.
- Outputs are registered: the pulse appears on cen[0] the cycle after the decision, for exactly 1 cycle.
- Sub-division:
  - cnt is a W-1 bit counter that increments, with wrap-around, on each pulse decision.
  - cen[k] (k>=1) = pulse && cnt[k-1:0]==0.
  - cenb[k-1] = pulse && cnt[k-1:0]==2^(k-1).
  - Hence cen[k] and cenb[k-1] never coincide, and cen[k] implies cen[j] for all j<k.
- n and m are sampled every cycle; changes take effect on the next decision without clearing acc.
- Long-term rate of cen[0] is exactly n/m pulses per clock for 0<n<m.

Optional Feature:
- Macro: JTFRAME_FRACCEN_STATS_EN.
- Defined:
  - A free-running CNTW-bit window counter runs only while lock_s=1.
  - A CNTW+1 bit pulse counter counts cen[0] pulses.
  - At window wrap, cen_cnt is loaded with the count including the wrap-cycle pulse, and the counter restarts.
  - The pulse counter saturates at 2^CNTW.
  - Lock loss clears both counters; cen_cnt holds its last value.
- Not defined: cen_cnt is tied to 0 and no counters are synthesised.

Test Plan:
- rst=1 then release with lock=1, n=1, m=8, W=3:
  - first cen[0] appears 2 sync cycles plus 8 cycles after release, then every 8 cycles;
  - cen[1] every 16 cycles, cen[2] every 32 cycles;
  - cenb[0] is 8 cycles offset from cen[1].
- n=3, m=8 over 800 cycles: exactly 300 cen[0] pulses, never two in adjacent cycles, and acc is always <8.
- n=5, m=5, then n=7, m=5: cen[0] is high every cycle and acc stays 0. Then m=0: cen stays 0 and acc is frozen.
- Drop lock for 10 cycles mid-run:
  - outputs go 0 within 2 cycles;
  - on lock return, the first pulse timing restarts from acc=0 and cnt=0.
- Assert rst asynchronously between clock edges mid-pulse: cen and cenb go 0 immediately, without waiting for a clock edge.
- With STATS_EN, CNTW=8, n=1, m=4: cen_cnt=64 after each 256-cycle window; with n=m=1, cen_cnt=256.
